banked_mem_responder: RTL

Synthesizable responder for the banked memory interface. It is the far end of the burst port that the cacheline adapter drives, and it services 256-bit line reads and writes as 4 x 64-bit beats. Line storage is internal. Read latency is configurable, and the block keeps a small in-order queue of outstanding reads. It replaces the behavioural banked memory in cache and adapter integration benches, and it serves as an FPGA stand-in for DRAM.

---
 rtl/bmem_pkg.sv | 38 +++
 rtl/bmem_read_fifo.sv | 112 +++++++++++
 rtl/banked_mem_responder.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bmem_pkg.sv
// -----------------------------------------------------------------------------
// bmem_pkg
// Shared types and constants for the banked memory responder slice.
//   beat_t      : one 64-bit data beat on the burst port
//   line_t      : one 256-bit cache line (four beats, beat k in bits [64k+63:64k])
//   rd_entry_t  : one outstanding read (line-aligned address, line snapshot, age)
//   rsp_state_t : response FSM states
//   line_beat() : helper that extracts beat k from a line
// -----------------------------------------------------------------------------
package bmem_pkg;

    typedef logic [63:0]  beat_t;
    typedef logic [255:0] line_t;

    localparam int BEATS_PER_LINE   = 4;
    localparam int LINE_OFFSET_BITS = 5;

    // Wide enough for any practical READ_LATENCY; ages saturate anyway.
    localparam int AGE_BITS = 16;
    typedef logic [AGE_BITS-1:0] age_t;

    typedef struct packed {
        logic [31:0] addr;
        line_t       line;
        age_t        age;
    } rd_entry_t;

    typedef enum logic {
        RSP_IDLE,
        RSP_BURST
    } rsp_state_t;

    // Beat k of a line lives at bits [64k+63:64k].
    function automatic beat_t line_beat(input line_t l, input logic [1:0] k);
        return l[{k, 6'b000000} +: 64];
    endfunction

endpackage

// File: rtl/bmem_read_fifo.sv
// -----------------------------------------------------------------------------
// bmem_read_fifo
// In-order queue of accepted reads. Every stored entry ages by one each clock
// (saturating at MAX_AGE); an entry is "due" once its age reaches DUE_AGE.
// The head and the entry behind it are both exposed so the response FSM can
// chain bursts without an idle cycle.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (clears occupancy)
//   push          : store push_entry (ignored when full unless popping)
//   push_entry    : entry to store; its age field is forced to zero
//   pop           : discard the head entry
//   full, empty   : occupancy flags (full is occupancy before any pop)
//   head          : oldest entry
//   head_due      : head exists and is old enough to be returned
//   second        : entry behind the head
//   second_due    : second entry exists and is old enough to be returned
// -----------------------------------------------------------------------------
module bmem_read_fifo
    import bmem_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DUE_AGE = 7,
    parameter int MAX_AGE = 8
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  rd_entry_t push_entry,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output rd_entry_t head,
    output logic      head_due,
    output rd_entry_t second,
    output logic      second_due
);

    localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_BITS = $clog2(DEPTH + 1);

    logic [31:0]         addr_q [DEPTH];
    line_t               line_q [DEPTH];
    age_t                age_q  [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [PTR_BITS-1:0] sec_ptr;
    logic [CNT_BITS-1:0] count;
    logic                do_push;
    logic                do_pop;
    logic                unused_entry_age;

    assign full    = (count == CNT_BITS'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign sec_ptr = rd_ptr + 1'b1;

    assign unused_entry_age = ^push_entry.age;

    // Pointers and occupancy are the only state that must be cleared on reset;
    // a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset. All slots age every cycle; stale slots
    // are harmless because a push always restarts the slot at age zero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (age_q[i] < AGE_BITS'(MAX_AGE)) begin
                age_q[i] <= age_q[i] + 1'b1;
            end
        end
        if (do_push) begin
            addr_q[wr_ptr] <= push_entry.addr;
            line_q[wr_ptr] <= push_entry.line;
            age_q[wr_ptr]  <= '0;
        end
    end

    // Present the two oldest entries and whether each is ready to go out.
    always_comb begin
        head        = '0;
        second      = '0;
        head.addr   = addr_q[rd_ptr];
        head.line   = line_q[rd_ptr];
        head.age    = age_q[rd_ptr];
        second.addr = addr_q[sec_ptr];
        second.line = line_q[sec_ptr];
        second.age  = age_q[sec_ptr];
        head_due    = !empty && (age_q[rd_ptr] >= AGE_BITS'(DUE_AGE));
        second_due  = (count > CNT_BITS'(1)) && (age_q[sec_ptr] >= AGE_BITS'(DUE_AGE));
    end

endmodule

// File: rtl/banked_mem_responder.sv
// -----------------------------------------------------------------------------
// banked_mem_responder
// Far end of the burst port driven by the cacheline adapter. Stores
// LINE_COUNT 256-bit lines internally, accepts 4-beat line writes and line
// reads, and returns each read as a 4-beat burst no sooner than READ_LATENCY
// cycles after accept, strictly in accept order. Up to QUEUE_DEPTH reads may
// be outstanding.
//
// Parameters:
//   LINE_COUNT   : number of 32-byte lines stored (power of 2, >= 2)
//   READ_LATENCY : cycles from read accept to first rvalid beat (>= 2)
//   QUEUE_DEPTH  : maximum outstanding reads (power of 2, >= 2)
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   addr      : request byte address, bits [4:0] ignored
//   read      : read request, accepted on read && ready && !write
//   write     : write request on accept, then write beat valid
//   wdata     : write beat data
//   ready     : a new request can be accepted this cycle
//   raddr     : line-aligned address of the burst being returned
//   rdata     : read beat data
//   rvalid    : raddr/rdata valid this cycle
//   proto_err : (BMEM_PROTOCOL_CHECK_EN only) sticky protocol violation flag
//
// Optional feature macro: BMEM_PROTOCOL_CHECK_EN
// -----------------------------------------------------------------------------
module banked_mem_responder
    import bmem_pkg::*;
#(
    parameter int LINE_COUNT   = 256,
    parameter int READ_LATENCY = 8,
    parameter int QUEUE_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        read,
    input  logic        write,
    input  logic [63:0] wdata,
    output logic        ready,
    output logic [31:0] raddr,
    output logic [63:0] rdata,
    output logic        rvalid
`ifdef BMEM_PROTOCOL_CHECK_EN
    ,
    output logic        proto_err
`endif
);

    localparam int         IDX_BITS  = $clog2(LINE_COUNT);
    localparam logic [1:0] LAST_BEAT = 2'(BEATS_PER_LINE - 1);

    line_t               line_mem [LINE_COUNT];
    logic [IDX_BITS-1:0] line_idx;
    logic                ready_en;

    logic                wr_active;
    logic [1:0]          wr_cnt;
    logic [IDX_BITS-1:0] wr_idx;
    logic [191:0]        wr_buf;
    logic                accept_wr;
    logic                accept_rd;
    logic                commit;

    rd_entry_t           push_entry;
    rd_entry_t           head;
    rd_entry_t           second;
    logic                q_full;
    logic                q_empty;
    logic                q_pop;
    logic                head_due;
    logic                second_due;

    rsp_state_t          rsp_state;
    logic [1:0]          rsp_beat;
    logic [1:0]          beat_next;

    logic                unused_bits;

    assign line_idx  = addr[LINE_OFFSET_BITS +: IDX_BITS];
    assign ready     = ready_en && !wr_active && !q_full;
    assign accept_wr = write && ready;
    assign accept_rd = read && ready && !write;
    assign commit    = wr_active && (wr_cnt == LAST_BEAT);
    assign q_pop     = (rsp_state == RSP_BURST) && (rsp_beat == LAST_BEAT);
    assign beat_next = rsp_beat + 2'd1;

    assign unused_bits = ^{addr[LINE_OFFSET_BITS-1:0], head.age, second.age, q_empty};

    // ready is held low through reset and comes up on the first clock after
    // reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Write-beat counter: an accepted write occupies the next three cycles
    // unconditionally. Clearing it on reset is what discards a partial burst,
    // since the commit below can then never happen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_active <= 1'b0;
            wr_cnt    <= '0;
        end else if (accept_wr) begin
            wr_active <= 1'b1;
            wr_cnt    <= 2'd1;
        end else if (wr_active) begin
            if (wr_cnt == LAST_BEAT) begin
                wr_active <= 1'b0;
                wr_cnt    <= '0;
            end else begin
                wr_cnt <= wr_cnt + 2'd1;
            end
        end
    end

    // Collect beats 0..2 and the line index; the line is written to storage
    // together with beat 3 on the edge that ends the burst. Storage itself is
    // never reset.
    always_ff @(posedge clk) begin
        if (accept_wr) begin
            wr_idx         <= line_idx;
            wr_buf[63:0]   <= wdata;
        end else if (wr_active) begin
            case (wr_cnt)
                2'd1:    wr_buf[127:64]  <= wdata;
                2'd2:    wr_buf[191:128] <= wdata;
                default: wr_buf          <= wr_buf;
            endcase
        end
        if (commit) begin
            line_mem[wr_idx] <= {wdata, wr_buf};
        end
    end

    // The snapshot is taken from storage as it stands before the accept edge,
    // so a commit landing on that same edge is not seen by this read.
    always_comb begin
        push_entry      = '0;
        push_entry.addr = {addr[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
        push_entry.line = line_mem[line_idx];
    end

    bmem_read_fifo #(
        .DEPTH   (QUEUE_DEPTH),
        .DUE_AGE (READ_LATENCY - 1),
        .MAX_AGE (READ_LATENCY)
    ) u_read_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (accept_rd),
        .push_entry (push_entry),
        .pop        (q_pop),
        .full       (q_full),
        .empty      (q_empty),
        .head       (head),
        .head_due   (head_due),
        .second     (second),
        .second_due (second_due)
    );

    // Response FSM. A burst starts the cycle after the head becomes due and
    // runs four back-to-back beats. The head is popped on the edge ending
    // beat 3; if the entry behind it is already due, its beat 0 is loaded on
    // that same edge so consecutive bursts touch with no idle cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_state <= RSP_IDLE;
            rsp_beat  <= '0;
            rvalid    <= 1'b0;
            rdata     <= '0;
            raddr     <= '0;
        end else begin
            case (rsp_state)
                RSP_IDLE: begin
                    if (head_due) begin
                        rsp_state <= RSP_BURST;
                        rsp_beat  <= '0;
                        rvalid    <= 1'b1;
                        raddr     <= head.addr;
                        rdata     <= line_beat(head.line, 2'd0);
                    end
                end
                RSP_BURST: begin
                    if (rsp_beat != LAST_BEAT) begin
                        rsp_beat <= beat_next;
                        rdata    <= line_beat(head.line, beat_next);
                    end else if (second_due) begin
                        rsp_beat <= '0;
                        raddr    <= second.addr;
                        rdata    <= line_beat(second.line, 2'd0);
                    end else begin
                        rsp_state <= RSP_IDLE;
                        rsp_beat  <= '0;
                        rvalid    <= 1'b0;
                        rdata     <= '0;
                        raddr     <= '0;
                    end
                end
                default: begin
                    rsp_state <= RSP_IDLE;
                    rvalid    <= 1'b0;
                end
            endcase
        end
    end

`ifdef BMEM_PROTOCOL_CHECK_EN
    logic viol_both;
    logic viol_rd_in_beat;
    logic viol_wr_gap;
    logic viol_misalign;
    logic proto_viol;

    // Any of these initiator mistakes sets the sticky error flag.
    always_comb begin
        viol_both       = read && write;
        viol_rd_in_beat = wr_active && read;
        viol_wr_gap     = wr_active && !write;
        viol_misalign   = (accept_rd || accept_wr) && (addr[LINE_OFFSET_BITS-1:0] != '0);
        proto_viol      = viol_both || viol_rd_in_beat || viol_wr_gap || viol_misalign;
    end

    // Sticky until the next reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (proto_viol) begin
            proto_err <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    // Simulation-only report naming which rule was broken.
    always_ff @(posedge clk) begin
        if (!rst && proto_viol) begin
            $error("banked_mem_responder protocol: both=%0b rd_in_beat=%0b wr_gap=%0b misalign=%0b",
                   viol_both, viol_rd_in_beat, viol_wr_gap, viol_misalign);
        end
    end
`endif
`endif

endmodule
